tpiu_trace_capture: RTL and testbench

- Consumes the 4-bit TPIU parallel trace port (TRACEDATA), sampled once per clk.
- Finds TPIU full-word synchronisation (0x7FFFFFFF), aligns nibbles to bytes and strips sync words.
- Pushes aligned frame bytes, tagged with frame position, into an output byte FIFO with a valid/ready interface.
- Sits directly downstream of the trace source (real TPIU pins or the simulation trace generator), upstream of the capture-to-host buffer.

---
 rtl/tpiu_trace_capture_pkg.sv | 12 +
 rtl/tpiu_trace_capture_if.sv | 10 +
 rtl/tpiu_trace_capture_fifo.sv | 40 ++++
 rtl/tpiu_trace_capture.sv | 135 +++++++++++++
 tb/tb_tpiu_trace_capture.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpiu_trace_capture_pkg.sv
// Shared constants and types for the TPIU trace capture path.
package tpiu_trace_pkg;

    localparam logic [31:0] TPIU_FSYNC = 32'h7FFF_FFFF;
    localparam int          NIB_W      = 4;
    // Bytes held back before pushing: a sync match completes on its 4th byte,
    // so exactly the three preceding sync bytes are still held and get dropped.
    localparam int          HOLD_BYTES = 3;

    typedef enum logic {HUNT, ALIGNED} state_t;

endpackage

// File: rtl/tpiu_trace_capture_if.sv
// Byte stream from the trace capture block to the host-side buffer.
interface tpiu_trace_capture_if;
    logic [7:0] out_data;
    logic       out_first;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, out_first, out_valid, input out_ready);
    modport slave  (input out_data, out_first, out_valid, output out_ready);
endinterface

// File: rtl/tpiu_trace_capture_fifo.sv
// Show-ahead synchronous FIFO; head entry is readable while empty is low.
module tpiu_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         wr, rd;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/tpiu_trace_capture.sv
// TPIU nibble capture: full-word sync search, byte alignment, sync stripping.
// Optional TRACE_CAPTURE_STATS_EN adds sync_count/byte_count outputs.
module tpiu_trace_capture
    import tpiu_trace_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_BYTES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NIB_W-1:0] trace_data,
    input  logic             enable,
    input  logic             clear_flags,
    tpiu_trace_capture_if.master ob,
    output logic             locked,
    output logic             resync_err,
    output logic             overflow
`ifdef TRACE_CAPTURE_STATS_EN
    ,
    output logic [15:0]      sync_count,
    output logic [31:0]      byte_count
`endif
);
    localparam int         FI_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [1:0] HOLD = 2'(HOLD_BYTES);

    state_t          state, state_nxt;
    logic [31:0]     sr, sr_nxt;
    logic            match, nib_phase, realign, misalign, byte_done, push_req;
    logic [1:0]      win_cnt;
    logic [FI_W-1:0] frame_idx;
    logic            fifo_full, fifo_empty, fifo_pop, fifo_acc;
    logic [8:0]      fifo_rdata;

    assign sr_nxt = {trace_data, sr[31:NIB_W]};
    assign match  = (sr_nxt == TPIU_FSYNC);

    always_comb begin
        state_nxt = state;
        realign   = 1'b0;
        misalign  = 1'b0;
        byte_done = 1'b0;
        push_req  = 1'b0;
        if (enable) begin
            case (state)
                HUNT: if (match) begin
                    state_nxt = ALIGNED;
                    realign   = 1'b1;
                end
                ALIGNED: if (match) begin
                    realign  = 1'b1;
                    misalign = !nib_phase;
                end else if (nib_phase) begin
                    byte_done = 1'b1;
                    push_req  = (win_cnt == HOLD);
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= '0;
            nib_phase <= 1'b0;
            win_cnt   <= '0;
            frame_idx <= '0;
        end else begin
            state <= state_nxt;
            if (enable) sr <= sr_nxt;
            if (realign) begin
                nib_phase <= 1'b0;
                win_cnt   <= '0;
                frame_idx <= '0;
            end else if (enable && state == ALIGNED) begin
                nib_phase <= ~nib_phase;
                if (byte_done && !push_req) win_cnt <= win_cnt + 2'd1;
                // Position advances even when the byte is dropped on overflow.
                if (push_req)
                    frame_idx <= (frame_idx == FI_W'(FRAME_BYTES - 1)) ? '0 : frame_idx + 1'b1;
            end
        end
    end

    // After a completing nibble sr_nxt holds the last four bytes; the oldest is leaving.
    assign fifo_pop = ob.out_valid && ob.out_ready;
    assign fifo_acc = push_req && (!fifo_full || fifo_pop);

    tpiu_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .wdata ({frame_idx == '0, sr_nxt[7:0]}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ob.out_valid = !fifo_empty;
    assign ob.out_data  = fifo_empty ? 8'h00 : fifo_rdata[7:0];
    assign ob.out_first = !fifo_empty && fifo_rdata[8];
    assign locked       = (state == ALIGNED);

    always_ff @(posedge clk) begin
        if (reset) begin
            resync_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            resync_err <= misalign || (resync_err && !clear_flags);
            overflow   <= (push_req && !fifo_acc) || (overflow && !clear_flags);
        end
    end

`ifdef TRACE_CAPTURE_STATS_EN
    logic        sync_evt;
    logic [15:0] sync_base;
    logic [31:0] byte_base;

    assign sync_evt  = enable && (state == ALIGNED) && match;
    assign sync_base = clear_flags ? 16'd0 : sync_count;
    assign byte_base = clear_flags ? 32'd0 : byte_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_count <= '0;
            byte_count <= '0;
        end else begin
            sync_count <= (sync_evt && sync_base != 16'hFFFF) ? sync_base + 16'd1 : sync_base;
            byte_count <= byte_base + {31'd0, fifo_acc};
        end
    end
`endif
endmodule

// File: tb/tb_tpiu_trace_capture.sv
// Scoreboard bench for tpiu_trace_capture: nibble-level reference model + head monitor.
module tb_tpiu_trace_capture;
    localparam int DEPTH = 16;
    localparam int FRAME = 16;

    logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, clear_flags = 1'b0, out_ready = 1'b1;
    logic [3:0] trace_data = 4'h0;
    logic       locked, resync_err, overflow;
`ifdef TRACE_CAPTURE_STATS_EN
    logic [15:0] sync_count;
    logic [31:0] byte_count;
`endif

    tpiu_trace_capture_if bus();
    assign bus.out_ready = out_ready;

    tpiu_trace_capture #(.FIFO_DEPTH(DEPTH), .FRAME_BYTES(FRAME)) dut (
        .clk         (clk),
        .reset       (reset),
        .trace_data  (trace_data),
        .enable      (enable),
        .clear_flags (clear_flags),
        .ob          (bus),
        .locked      (locked),
        .resync_err  (resync_err),
        .overflow    (overflow)
`ifdef TRACE_CAPTURE_STATS_EN
        ,
        .sync_count  (sync_count),
        .byte_count  (byte_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit en_toggle = 0, rnd_mode = 0;

    // Reference model state: recent nibbles, held bytes, expected FIFO contents.
    bit         m_locked, m_phase, m_res, m_ovf;
    logic [3:0] m_lo;
    int         m_pos, m_sync, m_bytes;
    logic [3:0] hist[$];
    logic [7:0] held[$];
    logic [8:0] expq[$];
    logic [8:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_sync();
        if (hist.size() != 8) return 1'b0;
        for (int i = 0; i < 7; i++) if (hist[i] != 4'hF) return 1'b0;
        return hist[7] == 4'h7;
    endfunction

    task automatic emit(input logic [7:0] b);
        if (expq.size() >= DEPTH) m_ovf = 1;
        else begin
            expq.push_back({m_pos == 0, b});
            m_bytes++;
        end
        m_pos = (m_pos + 1) % FRAME;
    endtask

    task automatic m_step();
        if (reset) begin
            m_locked = 0; m_phase = 0; m_res = 0; m_ovf = 0;
            m_pos = 0; m_sync = 0; m_bytes = 0;
            hist.delete(); held.delete(); expq.delete();
            return;
        end
        if (clear_flags) begin m_res = 0; m_ovf = 0; m_sync = 0; m_bytes = 0; end
        if (!enable) return;
        hist.push_back(trace_data);
        if (hist.size() > 8) void'(hist.pop_front());
        if (is_sync()) begin
            if (m_locked) begin
                if (m_sync < 65535) m_sync++;
                if (!m_phase) m_res = 1;
            end
            m_locked = 1; m_phase = 0; m_pos = 0;
            held.delete();
        end else if (m_locked) begin
            if (!m_phase) begin
                m_lo = trace_data; m_phase = 1;
            end else begin
                m_phase = 0;
                held.push_back({trace_data, m_lo});
                if (held.size() > 3) emit(held.pop_front());
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_step();
    end

    // Monitor: compare DUT head and flags to the model away from the edge.
    initial forever begin
        @(negedge clk);
        chk("locked", 32'(locked), 32'(m_locked));
        chk("resync_err", 32'(resync_err), 32'(m_res));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("out_valid", 32'(bus.out_valid), 32'(expq.size() > 0));
        if (expq.size() > 0) begin
            if (bus.out_valid) chk("out_byte", 32'({bus.out_first, bus.out_data}), 32'(expq[0]));
            if (out_ready) void'(expq.pop_front());
        end
        if (bus.out_valid && out_ready) got.push_back({bus.out_first, bus.out_data});
`ifdef TRACE_CAPTURE_STATS_EN
        chk("sync_count", 32'(sync_count), 32'(m_sync));
        chk("byte_count", byte_count, 32'(m_bytes));
`endif
    end

    task automatic nib(input logic [3:0] n);
        if (en_toggle) begin
            enable = 0; trace_data = 4'($urandom);
            @(posedge clk); #1;
        end
        if (rnd_mode) begin
            out_ready   = ($urandom % 4) != 0;
            clear_flags = ($urandom % 64) == 0;
        end
        enable = 1; trace_data = n;
        @(posedge clk); #1;
        enable = 0; clear_flags = 0;
    endtask

    task automatic byt(input logic [7:0] b);
        nib(b[3:0]);
        nib(b[7:4]);
    endtask

    task automatic sync_word();
        repeat (7) nib(4'hF);
        nib(4'h7);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1; enable = 0;
        while (expq.size() > 0 && n < 200) begin
            @(posedge clk); n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_timeout", 32'(expq.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; clear_flags = 0; out_ready = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_flags", 32'({resync_err, overflow}), 32'd0);
        got.delete();
    endtask

    task automatic run_basic(input bit tog);
        do_reset();
        en_toggle = tog;
        sync_word();
        for (int i = 0; i < 20; i++) byt(8'(i));
        sync_word();
        en_toggle = 0;
        drain();
        chk("basic_count", 32'(got.size()), 32'd20);
        for (int i = 0; i < got.size() && i < 20; i++)
            chk("basic_byte", 32'(got[i]), 32'({i == 0 || i == 16, 8'(i)}));
        chk("basic_locked", 32'(locked), 32'd1);
`ifdef TRACE_CAPTURE_STATS_EN
        chk("basic_sync_count", 32'(sync_count), 32'd1);
        chk("basic_byte_count", byte_count, 32'd20);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;

        run_basic(0);

        // Extra nibble puts the following sync on the odd phase.
        do_reset();
        sync_word();
        for (int i = 0; i < 10; i++) byt(8'($urandom_range(0, 8'h7E)));
        nib(4'h3);
        sync_word();
        drain();
        chk("resync_flag", 32'(resync_err), 32'd1);
        chk("resync_locked", 32'(locked), 32'd1);
        got.delete();
        for (int i = 0; i < 8; i++) byt(8'(8'hC0 + i));
        sync_word();
        drain();
        chk("resync_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < got.size() && i < 8; i++)
            chk("resync_byte", 32'(got[i]), 32'({i == 0, 8'(8'hC0 + i)}));

        // Overflow with consumer stalled; three bytes stay held in the window.
        do_reset();
        out_ready = 0;
        sync_word();
        for (int i = 0; i < DEPTH + 5; i++) byt(8'(i));
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_valid", 32'(bus.out_valid), 32'd1);
        drain();
        chk("ovf_count", 32'(got.size()), 32'(DEPTH));
        for (int i = 0; i < got.size() && i < DEPTH; i++)
            chk("ovf_byte", 32'(got[i]), 32'({i == 0, 8'(i)}));
        clear_flags = 1;
        @(posedge clk); #1;
        clear_flags = 0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        run_basic(1);

        // Reset mid-frame, then a stream that can never contain a sync word.
        do_reset();
        sync_word();
        for (int i = 0; i < 5; i++) byt(8'(8'h20 + i));
        nib(4'h1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        for (int i = 0; i < 20; i++) nib(4'($urandom_range(0, 6)));
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);

        // Random traffic: occasional syncs, stray nibbles, stalls, enable gaps, clears.
        do_reset();
        rnd_mode = 1;
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom % 16);
            en_toggle = ($urandom % 4) == 0;
            if (r == 0) sync_word();
            else if (r == 1) nib(4'($urandom));
            else byt(8'($urandom));
        end
        rnd_mode = 0;
        en_toggle = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
